// File: rtl/adc_frame_reader.sv
// adc_frame_reader: SPI master for the MAX11125 ADC.
// Each accepted start runs one 16-bit frame. A manual-mode command for the
// requested channel goes out on adc_mosi while the 16-bit result word comes
// back on adc_miso: a 4-bit channel ID followed by 12 bits of data.
// The result is presented on data/data_ch with a one-cycle data_valid pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | csn high, waiting for start
// S_SETUP | csn low, first command bit on mosi, sclk low for DIV cycles
// S_HIGH  | sclk high for DIV cycles (miso sampled on the rising edge)
// S_LOW   | sclk low for DIV cycles (mosi advanced on the falling edge)
// S_DONE  | csn high, result published with data_valid for one cycle
// S_QUIET | csn high, busy held for QUIET cycles before the next frame
module adc_frame_reader #(
    parameter int DIV   = 2,
    parameter int QUIET = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  channel,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [3:0]  data_ch,
    output logic        adc_csn,
    output logic        adc_sclk,
    output logic        adc_mosi,
    input  logic        adc_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_QUIET
    } state_t;

    localparam logic [7:0] DIV_LOAD   = 8'(DIV - 1);
    localparam logic [7:0] QUIET_LOAD = 8'(QUIET - 1);

    state_t      state;
    logic [7:0]  phase;
    logic [3:0]  bit_cnt;
    logic [15:0] cmd;
    logic [15:0] rx;
    logic [15:0] cmd_word;
    logic        accept;

    // The command word is built as follows:
    //   - a leading 0
    //   - manual-scan opcode 0001
    //   - the 4-bit channel field, whose top bit is always 0
    //   - 0000
    //   - CHAN_ID = 1 and SWCNV = 1
    //   - a trailing 0
    assign cmd_word = {1'b0, 4'b0001, 1'b0, channel, 4'b0000, 1'b1, 1'b1, 1'b0};

    // Start is taken in IDLE. It is also taken on the last QUIET cycle, so a
    // held start restarts with csn high for exactly 1+QUIET cycles.
    assign accept = start && ((state == S_IDLE) ||
                              ((state == S_QUIET) && (phase == 8'd0)));

    // mosi is the top bit of the command shift register. That register is
    // clear whenever no frame is in progress, so mosi idles low.
    assign adc_mosi = cmd[15];

    // Frame sequencer with registered pin and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= 8'd0;
            bit_cnt    <= 4'd0;
            cmd        <= 16'd0;
            rx         <= 16'd0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data       <= 12'd0;
            data_ch    <= 4'd0;
            adc_csn    <= 1'b1;
            adc_sclk   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (accept) begin
                cmd      <= cmd_word;
                busy     <= 1'b1;
                adc_csn  <= 1'b0;
                adc_sclk <= 1'b0;
                phase    <= DIV_LOAD;
                state    <= S_SETUP;
            end else begin
                case (state)
                    S_SETUP: begin
                        if (phase == 8'd0) begin
                            adc_sclk <= 1'b1;
                            rx       <= {rx[14:0], adc_miso};
                            bit_cnt  <= 4'd15;
                            phase    <= DIV_LOAD;
                            state    <= S_HIGH;
                        end else begin
                            phase <= phase - 8'd1;
                        end
                    end
                    S_HIGH: begin
                        if (phase == 8'd0) begin
                            adc_sclk <= 1'b0;
                            cmd      <= {cmd[14:0], 1'b0};
                            phase    <= DIV_LOAD;
                            state    <= S_LOW;
                        end else begin
                            phase <= phase - 8'd1;
                        end
                    end
                    S_LOW: begin
                        if (phase != 8'd0) begin
                            phase <= phase - 8'd1;
                        end else if (bit_cnt == 4'd0) begin
                            adc_csn    <= 1'b1;
                            data_valid <= 1'b1;
                            data       <= rx[11:0];
                            data_ch    <= rx[15:12];
                            state      <= S_DONE;
                        end else begin
                            adc_sclk <= 1'b1;
                            rx       <= {rx[14:0], adc_miso};
                            bit_cnt  <= bit_cnt - 4'd1;
                            phase    <= DIV_LOAD;
                            state    <= S_HIGH;
                        end
                    end
                    S_DONE: begin
                        phase <= QUIET_LOAD;
                        state <= S_QUIET;
                    end
                    S_QUIET: begin
                        if (phase == 8'd0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            phase <= phase - 8'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for adc_frame_reader. Two instances share the stimulus:
// one uses DIV=2/QUIET=4 and the other uses DIV=1/QUIET=1.
// A timeline model predicts the expected pin levels and result words.
module tb_adc_frame_reader;

    localparam int NI = 2;

    typedef struct {
        logic [15:0] word;
        logic [15:0] cmd;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  channel = 3'd0;
    bit          force_en = 1'b0;
    logic [15:0] force_word = 16'h0;
    bit          finishing = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #20 clk = ~clk;

    // Edge index: constant across each posedge and its monitor sample.
    always @(negedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d cyc %0d: got %0h want %0h",
                      name, inst, cyc, act, exp);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int D       = (g == 0) ? 2 : 1;
        localparam int Q       = (g == 0) ? 4 : 1;
        localparam int FRAME   = 33 * D;
        localparam int GAP_END = FRAME + 1 + Q;

        logic        busy, dv, csn, sclk, mosi;
        logic        miso = 1'b0;
        logic [11:0] data;
        logic [3:0]  ch;

        adc_frame_reader #(.DIV(D), .QUIET(Q)) dut (
            .clk(clk), .reset(reset), .start(start), .channel(channel),
            .busy(busy), .data_valid(dv), .data(data), .data_ch(ch),
            .adc_csn(csn), .adc_sclk(sclk), .adc_mosi(mosi), .adc_miso(miso)
        );

        exp_t        exp_q[$];
        logic [15:0] miso_q[$];
        bit          act = 1'b0;
        int          e0 = 0;
        logic [15:0] cur = 16'h0;
        logic [15:0] cap = 16'h0;
        int          bi = 0;
        logic [11:0] last_data = 12'h0;
        logic [3:0]  last_ch = 4'h0;
        exp_t        e_new, e_got;
        logic [15:0] w;
        int          rel;
        bit          in_frame;
        logic [2:0]  pins_exp;

        // Reference timeline: decide whether this edge starts a frame.
        always @(posedge clk) begin
            if (reset) begin
                act = 1'b0;
            end else if (start && (!act || cyc >= e0 + GAP_END)) begin
                w = force_en ? force_word : 16'($urandom);
                act = 1'b1;
                e0 = cyc;
                e_new.word = w;
                e_new.cmd  = {1'b0, 4'b0001, 1'b0, channel, 4'b0000, 3'b110};
                e_new.t    = cyc + FRAME;
                exp_q.push_back(e_new);
                miso_q.push_back(w);
            end
        end

        always @(posedge reset) begin
            exp_q.delete();
            miso_q.delete();
            act = 1'b0;
            last_data = 12'h0;
            last_ch = 4'h0;
        end

        always @(posedge reset) begin
            #1;
            if (cyc > 0) begin
                check("async reset csn", g, 32'(csn), 32'(1));
                check("async reset sclk", g, 32'(sclk), 32'(0));
            end
        end

        // ADC model: MSB presented at csn fall, next bit after each sclk fall.
        always @(negedge csn) begin
            cur = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0;
            bi = 15;
            miso = cur[15];
            cap = 16'h0;
        end

        always @(negedge sclk) begin
            if (!csn && bi > 0) begin
                bi = bi - 1;
                miso = cur[bi];
            end
        end

        always @(posedge sclk) cap = {cap[14:0], mosi};

        // Monitor: compare pins every cycle and check results on data_valid.
        always @(posedge clk) begin
            #1;
            if (!finishing) begin
                rel = cyc - e0;
                in_frame = act && (rel < FRAME);
                pins_exp = {~in_frame,
                            in_frame && (rel >= D) && (((rel - D) / D) % 2 == 0),
                            act && (rel < GAP_END)};
                check("pins csn/sclk/busy", g, 32'({csn, sclk, busy}), 32'(pins_exp));
                if (dv) begin
                    check("data_valid expected", g, 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) begin
                        e_got = exp_q.pop_front();
                        check("dv time", g, 32'(cyc), 32'(e_got.t));
                        check("data", g, 32'(data), 32'(e_got.word[11:0]));
                        check("data_ch", g, 32'(ch), 32'(e_got.word[15:12]));
                        check("mosi cmd", g, 32'(cap), 32'(e_got.cmd));
                        last_data = e_got.word[11:0];
                        last_ch = e_got.word[15:12];
                    end
                end else begin
                    check("data hold", g, 32'({ch, data}), 32'({last_ch, last_data}));
                    if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
                        check("data_valid missing", g, 32'(dv), 32'(1));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end

        always @(posedge finishing) begin
            check("pending frames", g, 32'(exp_q.size()), 32'(0));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            channel = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Single frame on channel 5, with extra starts at E0+10 and E0+68.
        force_en = 1'b1;
        force_word = 16'h5ABC;
        channel = 3'd5;
        pulse_start();
        repeat (9) @(negedge clk);
        pulse_start();
        repeat (57) @(negedge clk);
        pulse_start();
        repeat (80) @(negedge clk);

        // Channel 7 with an all-ones return word.
        force_word = 16'hFFFF;
        channel = 3'd7;
        pulse_start();
        repeat (90) @(negedge clk);
        force_en = 1'b0;

        // Back-to-back frames with start held high.
        start = 1'b1;
        repeat (300) begin
            @(negedge clk);
            channel = 3'($urandom);
        end
        start = 1'b0;
        repeat (100) @(negedge clk);

        // Reset about 30 cycles into a frame, then a fresh frame afterwards.
        pulse_start();
        repeat (29) @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);

        // Random start traffic.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            channel = 3'($urandom);
        end
        start = 1'b0;
        repeat (150) @(negedge clk);

        finishing = 1'b1;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
